// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions, special
// register indices and the bubble encoding used across pipeline stages.
package proc_isa_pkg;

    localparam int ISA_INSN_W = 32;
    localparam int ISA_OPC_W  = 5;
    localparam int ISA_REG_W  = 5;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;

    // Opcodes
    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // Special registers
    localparam logic [4:0] R0_ZERO    = 5'd0;
    localparam logic [4:0] R30_STATUS = 5'd30;
    localparam logic [4:0] R31_LINK   = 5'd31;

    localparam logic [31:0] ISA_NOP_INSN = 32'h0000_0000;

    // Field extraction helpers
    function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
        return insn[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [4:0] insn_rd(input logic [31:0] insn);
        return insn[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] insn_rs(input logic [31:0] insn);
        return insn[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] insn_rt(input logic [31:0] insn);
        return insn[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/src_reg_decode.sv
// Combinational source-register decode: which registers an instruction
// reads on ports A and B, and whether each port is actually used.
// Unused ports drive address 0 so they never collide with a real hazard.
module src_reg_decode
    import proc_isa_pkg::*;
(
    input  logic [31:0] insn,
    output logic [4:0]  addr_a,
    output logic [4:0]  addr_b,
    output logic        uses_a,
    output logic        uses_b
);

    logic [4:0] opc_s;
    logic [4:0] rd_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;

    assign opc_s = insn_opcode(insn);
    assign rd_s  = insn_rd(insn);
    assign rs_s  = insn_rs(insn);
    assign rt_s  = insn_rt(insn);

    // Map opcode to source register fields for both read ports
    always_comb begin
        addr_a = R0_ZERO;
        addr_b = R0_ZERO;
        uses_a = 1'b0;
        uses_b = 1'b0;
        case (opc_s)
            OP_ALU: begin
                addr_a = rs_s;
                addr_b = rt_s;
                uses_a = 1'b1;
                uses_b = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                addr_a = rs_s;
                uses_a = 1'b1;
            end
            OP_SW: begin
                addr_a = rs_s;
                addr_b = rd_s;
                uses_a = 1'b1;
                uses_b = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                addr_a = rd_s;
                addr_b = rs_s;
                uses_a = 1'b1;
                uses_b = 1'b1;
            end
            OP_JR: begin
                addr_a = rd_s;
                uses_a = 1'b1;
            end
            OP_BEX: begin
                addr_a = R30_STATUS;
                uses_a = 1'b1;
            end
            default: begin
                addr_a = R0_ZERO;
                addr_b = R0_ZERO;
                uses_a = 1'b0;
                uses_b = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode / register-read stage: derives source addresses from the F/D
// instruction, reads the register file with writeback bypass, and latches
// the result into D/X. Inserts a one-cycle bubble on load-use hazards and
// squashes on flush from execute.
module decode_operand_stage
    import proc_isa_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          REG_W    = 5,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       fd_insn,
    input  logic [31:0]       fd_pc,
    input  logic              fd_valid,
    input  logic              flush,
    output logic [REG_W-1:0]  ctrl_readRegA,
    output logic [REG_W-1:0]  ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_writeEnable,
    input  logic [REG_W-1:0]  ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    output logic              stall_fd,
    output logic [31:0]       dx_insn,
    output logic [31:0]       dx_pc,
    output logic [DATA_W-1:0] dx_a,
    output logic [DATA_W-1:0] dx_b,
    output logic              dx_valid,
    output logic [31:0]       stall_count
);

    logic [4:0]        fd_addr_a_s;
    logic [4:0]        fd_addr_b_s;
    logic              fd_uses_a_s;
    logic              fd_uses_b_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [4:0]        dx_rd_s;
    logic              dx_is_lw_s;
    logic              hazard_s;

    logic [31:0]       dx_insn_r;
    logic [31:0]       dx_pc_r;
    logic [DATA_W-1:0] dx_a_r;
    logic [DATA_W-1:0] dx_b_r;
    logic              dx_valid_r;
    logic [31:0]       stall_count_r;

    src_reg_decode u_fd_decode (
        .insn   (fd_insn),
        .addr_a (fd_addr_a_s),
        .addr_b (fd_addr_b_s),
        .uses_a (fd_uses_a_s),
        .uses_b (fd_uses_b_s)
    );

    assign ctrl_readRegA = fd_addr_a_s;
    assign ctrl_readRegB = fd_addr_b_s;

    // Operand A: r0 reads zero, otherwise bypass a same-cycle writeback
    always_comb begin
        op_a_s = data_readRegA;
        if (fd_addr_a_s == R0_ZERO) begin
            op_a_s = {DATA_W{1'b0}};
        end else if (ctrl_writeEnable && (ctrl_writeReg == fd_addr_a_s)) begin
            op_a_s = data_writeReg;
        end else begin
            op_a_s = data_readRegA;
        end
    end

    // Operand B: same selection as A on the second read port
    always_comb begin
        op_b_s = data_readRegB;
        if (fd_addr_b_s == R0_ZERO) begin
            op_b_s = {DATA_W{1'b0}};
        end else if (ctrl_writeEnable && (ctrl_writeReg == fd_addr_b_s)) begin
            op_b_s = data_writeReg;
        end else begin
            op_b_s = data_readRegB;
        end
    end

    assign dx_rd_s    = insn_rd(dx_insn_r);
    assign dx_is_lw_s = (insn_opcode(dx_insn_r) == OP_LW);

    // Load-use hazard: a load in D/X whose destination the F/D instruction reads
    always_comb begin
        hazard_s = 1'b0;
        if (dx_valid_r && dx_is_lw_s && (dx_rd_s != R0_ZERO) && fd_valid) begin
            hazard_s = (fd_uses_a_s && (fd_addr_a_s == dx_rd_s)) ||
                       (fd_uses_b_s && (fd_addr_b_s == dx_rd_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush squashes the instruction, so there is nothing left to stall
    assign stall_fd = hazard_s && !flush;

    // D/X latch and stall counter: reset > flush > hazard > normal load
    always_ff @(posedge clock) begin
        if (reset) begin
            dx_insn_r     <= NOP_INSN;
            dx_pc_r       <= 32'h0000_0000;
            dx_a_r        <= {DATA_W{1'b0}};
            dx_b_r        <= {DATA_W{1'b0}};
            dx_valid_r    <= 1'b0;
            stall_count_r <= 32'h0000_0000;
        end else if (flush || hazard_s || !fd_valid) begin
            dx_insn_r  <= NOP_INSN;
            dx_pc_r    <= 32'h0000_0000;
            dx_a_r     <= {DATA_W{1'b0}};
            dx_b_r     <= {DATA_W{1'b0}};
            dx_valid_r <= 1'b0;
            if (!flush && hazard_s && (stall_count_r != 32'hFFFF_FFFF)) begin
                stall_count_r <= stall_count_r + 32'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end else begin
            dx_insn_r     <= fd_insn;
            dx_pc_r       <= fd_pc;
            dx_a_r        <= op_a_s;
            dx_b_r        <= op_b_s;
            dx_valid_r    <= 1'b1;
            stall_count_r <= stall_count_r;
        end
    end

    assign dx_insn     = dx_insn_r;
    assign dx_pc       = dx_pc_r;
    assign dx_a        = dx_a_r;
    assign dx_b        = dx_b_r;
    assign dx_valid    = dx_valid_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed scenarios followed by random
// instruction streams, all checked against a behavioural pipeline model.
module tb_decode_operand_stage;

    logic        clock;
    logic        reset;
    logic [31:0] fd_insn;
    logic [31:0] fd_pc;
    logic        fd_valid;
    logic        flush;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        stall_fd;
    logic [31:0] dx_insn;
    logic [31:0] dx_pc;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic        dx_valid;
    logic [31:0] stall_count;

    // Register file model; r0 deliberately holds garbage
    logic [31:0] rf [32];
    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    // Reference D/X state
    logic [31:0] m_insn, m_pc, m_a, m_b;
    logic        m_valid;
    longint      m_cnt;

    int total = 0;
    int fails = 0;

    decode_operand_stage dut (
        .clock            (clock),
        .reset            (reset),
        .fd_insn          (fd_insn),
        .fd_pc            (fd_pc),
        .fd_valid         (fd_valid),
        .flush            (flush),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .stall_fd         (stall_fd),
        .dx_insn          (dx_insn),
        .dx_pc            (dx_pc),
        .dx_a             (dx_a),
        .dx_b             (dx_b),
        .dx_valid         (dx_valid),
        .stall_count      (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int opc, input int rd, input int rs, input int rt);
        logic [31:0] w;
        w = {opc[4:0], rd[4:0], rs[4:0], rt[4:0], 12'h000};
        return w;
    endfunction

    // Which registers an instruction reads, straight from the ISA table
    task automatic ref_sources(input logic [31:0] insn, output logic [4:0] a, output logic [4:0] b,
                               output logic ua, output logic ub);
        logic [4:0] rd, rs, rt;
        int opc;
        rd = insn[26:22]; rs = insn[21:17]; rt = insn[16:12];
        opc = int'(insn[31:27]);
        a = 5'd0; b = 5'd0; ua = 1'b0; ub = 1'b0;
        if (opc == 0)                    begin a = rs; b = rt; ua = 1'b1; ub = 1'b1; end
        else if (opc == 5 || opc == 8)   begin a = rs; ua = 1'b1; end
        else if (opc == 7)               begin a = rs; b = rd; ua = 1'b1; ub = 1'b1; end
        else if (opc == 2 || opc == 6)   begin a = rd; b = rs; ua = 1'b1; ub = 1'b1; end
        else if (opc == 4)               begin a = rd; ua = 1'b1; end
        else if (opc == 22)              begin a = 5'd30; ua = 1'b1; end
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] addr, input logic we,
                                                input logic [4:0] wr, input logic [31:0] wd);
        if (addr == 5'd0) return 32'h0;
        if (we && wr == addr) return wd;
        return rf[addr];
    endfunction

    // One pipeline cycle: drive, check combinational outputs, clock, check D/X
    task automatic step(input logic [31:0] insn, input logic [31:0] pc, input logic v,
                        input logic fl, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic rst);
        logic [4:0]  ea, eb;
        logic        ua, ub, haz, bubble;
        logic [31:0] oa, ob;
        @(negedge clock);
        fd_insn = insn; fd_pc = pc; fd_valid = v; flush = fl;
        ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd; reset = rst;
        #1;
        ref_sources(insn, ea, eb, ua, ub);
        haz = m_valid && (m_insn[31:27] == 5'd8) && (m_insn[26:22] != 5'd0) && v &&
              ((ua && ea == m_insn[26:22]) || (ub && eb == m_insn[26:22]));
        oa = ref_operand(ea, we, wr, wd);
        ob = ref_operand(eb, we, wr, wd);
        check("readRegA", {27'd0, ctrl_readRegA}, {27'd0, ea});
        check("readRegB", {27'd0, ctrl_readRegB}, {27'd0, eb});
        if (!rst) check("stall_fd", {31'd0, stall_fd}, {31'd0, haz && !fl});
        @(posedge clock);
        bubble = 1'b1;
        if (rst) begin
            m_cnt = 0;
        end else if (!fl && haz) begin
            m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        end else if (!fl && v) begin
            bubble = 1'b0;
        end
        if (bubble) begin
            m_insn = 32'h0; m_pc = 32'h0; m_a = 32'h0; m_b = 32'h0; m_valid = 1'b0;
        end else begin
            m_insn = insn; m_pc = pc; m_a = oa; m_b = ob; m_valid = 1'b1;
        end
        #1;
        check("dx_insn", dx_insn, m_insn);
        check("dx_pc", dx_pc, m_pc);
        check("dx_a", dx_a, m_a);
        check("dx_b", dx_b, m_b);
        check("dx_valid", {31'd0, dx_valid}, {31'd0, m_valid});
        check("stall_count", stall_count, m_cnt[31:0]);
        if (we && wr != 5'd0) rf[wr] = wd;
    endtask

    int opc_tab [12] = '{0, 5, 8, 7, 2, 6, 4, 22, 1, 3, 21, 8};

    initial begin
        logic [31:0] add_i, lw_i, ri;
        int opc;
        fd_insn = 32'h0; fd_pc = 32'h0; fd_valid = 1'b0; flush = 1'b0;
        ctrl_writeEnable = 1'b0; ctrl_writeReg = 5'd0; data_writeReg = 32'h0; reset = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF; rf[1] = 32'd5; rf[2] = 32'd7;
        m_insn = 32'h0; m_pc = 32'h0; m_a = 32'h0; m_b = 32'h0; m_valid = 1'b0; m_cnt = 0;

        // Reset state
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        check("reset_insn", dx_insn, 32'h0000_0000);
        check("reset_count", stall_count, 32'h0);

        // add r3,r1,r2
        add_i = mk(0, 3, 1, 2);
        step(add_i, 32'd11, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("add_a", dx_a, 32'd5);
        check("add_b", dx_b, 32'd7);
        check("add_valid", {31'd0, dx_valid}, 32'd1);
        // bypass r2=99
        step(add_i, 32'd12, 1'b1, 1'b0, 1'b1, 5'd2, 32'd99, 1'b0);
        check("bypass_b", dx_b, 32'd99);
        // write r0 while reading r0
        step(mk(0, 3, 0, 2), 32'd13, 1'b1, 1'b0, 1'b1, 5'd0, 32'd42, 1'b0);
        check("r0_zero", dx_a, 32'd0);

        // Load-use: lw r4,0(r1) then add r5,r4,r2
        lw_i = mk(8, 4, 1, 0);
        step(lw_i, 32'd20, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(mk(0, 5, 4, 2), 32'd21, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("lu_bubble", {31'd0, dx_valid}, 32'd0);
        check("lu_count", stall_count, 32'd1);
        step(mk(0, 5, 4, 2), 32'd21, 1'b1, 1'b0, 1'b1, 5'd4, 32'd77, 1'b0);
        check("lu_release_a", dx_a, 32'd77);

        // Same hazard under flush
        step(lw_i, 32'd30, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(mk(0, 5, 4, 2), 32'd31, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        check("flush_count", stall_count, 32'd1);

        // Source decode coverage
        step(mk(2, 6, 7, 0), 32'd40, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(mk(7, 8, 9, 4), 32'd41, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(mk(22, 0, 0, 0), 32'd42, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(mk(8, 0, 3, 0), 32'd43, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(mk(3, 0, 0, 0), 32'd44, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("jal_no_stall", stall_count, 32'd1);

        // Reset mid-run with a valid D/X
        step(add_i, 32'd50, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(lw_i, 32'd51, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        check("midreset_valid", {31'd0, dx_valid}, 32'd0);

        // Saturation: preload counter just below max, then two stalls
        force dut.stall_count_r = 32'hFFFF_FFFE;
        #1 release dut.stall_count_r;
        m_cnt = 64'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            step(lw_i, 32'd60, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
            step(mk(0, 5, 4, 2), 32'd61, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        end
        check("saturate", stall_count, 32'hFFFF_FFFF);

        // Random streams biased toward load-use collisions
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int n = 0; n < 500; n++) begin
            opc = opc_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) opc = int'($urandom_range(0, 31));
            ri = mk(opc, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
            ri[11:0] = 12'($urandom);
            step(ri, $urandom, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Register-read (decode) stage of the 5-stage pipeline.
- Consumes the F/D latch instruction and derives the two source register addresses.
- Reads the register file, bypassing from the writeback port when needed.
- Registers everything into the D/X latch, stalling on load-use hazards and squashing on taken branches.
- This block is the reader of the register file that the writeback unit writes.

Parameters:
- DATA_W, 32, datapath / register width
- REG_W, 5, register address width (32 registers; r0 hardwired 0)
- NOP_INSN, 32'h0000_0000, encoding inserted as a bubble

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- fd_insn  in  32  instruction from F/D latch
- fd_pc  in  32  PC+1 from F/D latch
- fd_valid  in  1  F/D holds a real instruction
- flush  in  1  taken branch/jump resolved in execute; squash decode
- ctrl_readRegA  out  5  register file read address A (combinational)
- ctrl_readRegB  out  5  register file read address B (combinational)
- data_readRegA  in  32  register file read data A (async read)
- data_readRegB  in  32  register file read data B (async read)
- ctrl_writeEnable  in  1  writeback write enable (bypass source)
- ctrl_writeReg  in  5  writeback destination
- data_writeReg  in  32  writeback data
- stall_fd  out  1  hold PC and F/D latch this cycle
- dx_insn  out  32  D/X latched instruction
- dx_pc  out  32  D/X latched PC+1
- dx_a  out  32  D/X operand A
- dx_b  out  32  D/X operand B
- dx_valid  out  1  D/X holds a real instruction
- stall_count  out  32  saturating count of load-use stall cycles

Behaviour:
- Fields: opcode = insn[31:27], rd = [26:22], rs = [21:17], rt = [16:12].
- Source decode (addr / uses flag):
  - R-type 00000: A=rs, B=rt
  - addi 00101, lw 01000: A=rs, B unused
  - sw 00111: A=rs, B=rd
  - bne 00010, blt 00110: A=rd, B=rs
  - jr 00100: A=rd, B unused
  - bex 10110: A=30, B unused
  - j, jal, setx, anything else: A and B unused
  - An unused port drives address 0.
- Bypass, per port:
  - If ctrl_writeEnable && ctrl_writeReg == addr && addr != 0, the operand is data_writeReg.
  - Otherwise the operand is the register-file data.
  - Address 0 always yields 0, regardless of regfile contents or bypass.
- Load-use hazard:
  - Condition: dx_valid && dx opcode == lw && dx rd != 0 && fd_valid && a used source addr equals dx rd.
  - When set (and no flush): stall_fd=1; D/X loads bubble (insn=NOP_INSN, a=b=0, pc=0, valid=0); stall_count increments, saturating at 32'hFFFF_FFFF.
- Flush: highest priority. D/X loads bubble, stall_fd=0, stall_count unchanged. A flush coincident with a hazard suppresses the stall.
- Normal cycle: D/X <= {fd_insn, fd_pc, operand A, operand B, fd_valid}. Latency is 1 cycle from F/D to D/X.
- fd_valid=0: D/X loads bubble, with no stall and no count.
- Stalls last exactly one cycle per lw. The next cycle D/X holds the bubble, so the hazard clears.
- stall_fd is combinational from the current D/X and F/D contents.
- Reset (synchronous): dx_insn=NOP_INSN, dx_pc=0, dx_a=0, dx_b=0, dx_valid=0, stall_count=0.
  - Reset takes priority over flush and stall.
  - Reset mid-stall drops the pending instruction's D/X copy; the F/D side is reset upstream.

Decomposition:
- Shared package `proc_isa_pkg`, also used by writeback/execute:
  - opcode constants (ALU, ADDI, SW, LW, BNE, BLT, J, JAL, JR, BEX, SETX)
  - field bit positions
  - R30_STATUS and R31_LINK register indices
  - NOP_INSN
- One natural sub-module: `src_reg_decode`. It is combinational: insn -> {addrA, addrB, usesA, usesB}. It is reused by hazard logic.
- Bypass muxes and the D/X latch stay in the top module.

Test Plan:
- add r3,r1,r2 with regfile r1=5, r2=7, no writeback: next cycle dx_a=5, dx_b=7, dx_valid=1, stall_fd=0.
- Same add while writeback writes r2=99: dx_b=99. Writeback to r0 of 42 while reading r0 gives dx_a=0.
- lw r4,0(r1) in D/X, then add r5,r4,r2 in F/D: stall_fd=1 one cycle; D/X gets bubble (dx_valid=0); stall_count 0->1. Next cycle the add latches with stall_fd=0.
- Same hazard with flush=1: no stall, D/X bubble, stall_count unchanged.
- Source decode coverage:
  - bne r6,r7,off: ctrl_readRegA=6, ctrl_readRegB=7.
  - sw r8,4(r9): A=9, B=8.
  - bex: A=30.
  - jal: A=B=0, and no stall even if D/X is lw r0.
- Assert reset mid-run with dx_valid=1: next cycle all dx_* =0/NOP, stall_count=0. Preload stall_count near max and confirm it saturates at FFFF_FFFF.
